// File: rtl/fsk_tx_sequencer.sv
// fsk_tx_sequencer: turns a framed byte stream into enable/phase drive for the 8-bit FSK modulator.
//
// A frame is an alternating 1,0,... preamble followed by data bytes sent MSB first. Every bit
// lasts one full sweep of the 256-entry phase table: 256/PHASE_STEP sample strobes.
// A one-byte holding buffer decouples the valid/ready input from the bit timing.
// If the next byte is missing at a byte boundary and the current byte was not marked last,
// the frame is aborted.
//
// Optional feature: define FSK_PARITY_EN to append an even-parity bit after each byte's
// 8 data bits. The parity bit is the XOR of the 8 data bits.
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   sample_en    sample-rate strobe; phase and bit state advance only when high
//   in_data      data byte
//   in_valid     in_data/in_last valid
//   in_last      byte is the final byte of the frame
//   in_ready     byte accepted when in_valid & in_ready (combinational)
//   fsk_enable   current bit to the modulator (1 = table1, 0 = table2)
//   fsk_phase    phase index to the modulator
//   busy         frame in progress (preamble or data)
//   frame_done   one-cycle pulse at normal frame end
//   underrun     one-cycle pulse when a frame is aborted for lack of a byte
module fsk_tx_sequencer #(
    parameter int unsigned PHASE_STEP    = 32,
    parameter int unsigned PREAMBLE_BITS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_en,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       fsk_enable,
    output logic [7:0] fsk_phase,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PREAMBLE = 2'd1;
    localparam logic [1:0] ST_DATA     = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

`ifdef FSK_PARITY_EN
    localparam int unsigned BITS_PER_BYTE = 9;
`else
    localparam int unsigned BITS_PER_BYTE = 8;
`endif

    localparam logic [7:0] STEP       = 8'(PHASE_STEP);
    localparam logic [7:0] LAST_PHASE = 8'(256 - PHASE_STEP);
    localparam logic [6:0] PRE_LAST   = 7'(PREAMBLE_BITS - 1);
    localparam logic [3:0] LAST_BIT   = 4'(BITS_PER_BYTE - 1);

    logic [1:0] state;
    logic [7:0] buf_data;
    logic       buf_full;
    logic       buf_last;
    logic       last_seen;   // a byte flagged last has been accepted in this frame
    logic [6:0] shreg;       // bits still to send of the current byte; MSB is next
    logic       cur_last;    // byte currently on air is the final one
    logic [3:0] bit_idx;
    logic [6:0] pre_cnt;
`ifdef FSK_PARITY_EN
    logic       par_q;
`endif

    logic       handshake;
    logic       bit_end;
    logic       byte_end;
    logic       pre_end;
    logic       load_byte;
    logic [7:0] next_byte;
    logic       next_last;

    always_comb begin
        in_ready = 1'b0;
        case (state)
            ST_IDLE:              in_ready = 1'b1;
            ST_PREAMBLE, ST_DATA: in_ready = ~buf_full & ~last_seen;
            default:              in_ready = 1'b0;
        endcase
    end

    assign handshake = in_valid & in_ready;
    assign bit_end   = sample_en & (fsk_phase == LAST_PHASE);
    assign byte_end  = (state == ST_DATA) & bit_end & (bit_idx == LAST_BIT);
    assign pre_end   = (state == ST_PREAMBLE) & bit_end & (pre_cnt == PRE_LAST);

    // A byte boundary with an empty buffer but a same-cycle handshake bypasses the buffer.
    assign load_byte = pre_end | (byte_end & (buf_full | handshake));
    assign next_byte = buf_full ? buf_data : in_data;
    assign next_last = buf_full ? buf_last : in_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            fsk_phase  <= 8'd0;
            fsk_enable <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            buf_data   <= 8'd0;
            buf_full   <= 1'b0;
            buf_last   <= 1'b0;
            last_seen  <= 1'b0;
            shreg      <= 7'd0;
            cur_last   <= 1'b0;
            bit_idx    <= 4'd0;
            pre_cnt    <= 7'd0;
`ifdef FSK_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            underrun   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        buf_data   <= in_data;
                        buf_last   <= in_last;
                        buf_full   <= 1'b1;
                        last_seen  <= in_last;
                        pre_cnt    <= 7'd0;
                        fsk_phase  <= 8'd0;
                        fsk_enable <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_PREAMBLE;
                    end
                end

                ST_PREAMBLE: begin
                    if (sample_en) begin
                        // Wraps to 0 naturally on the bit boundary.
                        fsk_phase <= fsk_phase + STEP;
                        if (bit_end && !pre_end) begin
                            pre_cnt    <= pre_cnt + 7'd1;
                            // Preamble bit k is 1 for even k; next bit is k = pre_cnt + 1.
                            fsk_enable <= pre_cnt[0];
                        end
                        if (pre_end) begin
                            state <= ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    if (handshake) begin
                        last_seen <= in_last;
                        if (!byte_end) begin
                            buf_data <= in_data;
                            buf_last <= in_last;
                            buf_full <= 1'b1;
                        end
                    end
                    if (sample_en) begin
                        fsk_phase <= fsk_phase + STEP;
                        if (bit_end && !byte_end) begin
                            bit_idx    <= bit_idx + 4'd1;
                            shreg      <= {shreg[5:0], 1'b0};
                            fsk_enable <= shreg[6];
`ifdef FSK_PARITY_EN
                            if (bit_idx == 4'd7) begin
                                fsk_enable <= par_q;
                            end
`endif
                        end
                        if (byte_end && !load_byte) begin
                            state      <= cur_last ? ST_DONE : ST_IDLE;
                            frame_done <= cur_last;
                            underrun   <= ~cur_last;
                            busy       <= 1'b0;
                            fsk_enable <= 1'b1;
                            last_seen  <= 1'b0;
                        end
                    end
                end

                ST_DONE: begin
                    fsk_phase  <= 8'd0;
                    fsk_enable <= 1'b1;
                    state      <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase

            if (load_byte) begin
                shreg      <= next_byte[6:0];
                fsk_enable <= next_byte[7];
                cur_last   <= next_last;
                bit_idx    <= 4'd0;
                buf_full   <= 1'b0;
`ifdef FSK_PARITY_EN
                par_q      <= ^next_byte;
`endif
            end
        end
    end

endmodule

// File: doc/fsk_tx_sequencer.md
Name: fsk_tx_sequencer

Overview:
- Drives the 8-bit FSK modulator's `enable`/`phase` inputs from a byte stream. Each byte is sent as a framed, MSB-first bit sequence.
- Per frame: alternating preamble, then data bytes accepted over a valid/ready handshake with a one-byte holding buffer.
- Per bit, the phase is swept across the 256-entry table, so every bit period covers exactly one full table sweep. `fsk_enable` carries the bit value.
- Sits between the CRC/framing path and the FSK modulator.

Parameters:
- PHASE_STEP, 32, phase increment per sample strobe; power of two, 1..128; samples per bit = 256/PHASE_STEP
- PREAMBLE_BITS, 8, number of preamble bits; even, 2..64

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- sample_en  in  1  sample-rate strobe; phase/bit state advances only on cycles where it is high
- in_data  in  8  data byte
- in_valid  in  1  in_data/in_last valid
- in_last  in  1  byte is final byte of frame
- in_ready  out  1  byte accepted when in_valid & in_ready
- fsk_enable  out  1  bit to modulator enable (1 = table1, 0 = table2)
- fsk_phase  out  8  phase index to modulator
- busy  out  1  frame in progress (PREAMBLE or DATA)
- frame_done  out  1  one-cycle pulse at normal frame end
- underrun  out  1  one-cycle pulse on frame abort due to missing byte

Behaviour:
- Reset (asynchronous, any state): state=IDLE, fsk_phase=0, fsk_enable=1, busy=0, frame_done=0, underrun=0, buffer empty, last flag clear. in_ready follows from IDLE (=1).
- All outputs are registered except in_ready, which is combinational from state and buffer flags.
- States: IDLE, PREAMBLE, DATA, DONE.
- IDLE:
  - in_ready=1, fsk_phase=0, fsk_enable=1.
  - On handshake: byte and last flag go into the holding buffer; next state PREAMBLE with fsk_phase=0, fsk_enable=1 (first preamble bit).
  - The handshake is not gated by sample_en.
- Sample strobe: each sample_en cycle in PREAMBLE/DATA, fsk_phase <= fsk_phase + PHASE_STEP (mod 256).
- Bit boundary: sample_en high and fsk_phase == 256-PHASE_STEP. On that edge the phase wraps to 0 and fsk_enable takes the next bit on the same edge.
- PREAMBLE:
  - Bits are 1,0,1,0,..., PREAMBLE_BITS of them.
  - At the final preamble boundary: buffer moves to the shift register, the buffer empties, state goes to DATA, and fsk_enable = byte[7].
- DATA:
  - Bits are sent MSB first, one per bit period.
  - in_ready = buffer empty AND last flag clear (no bytes accepted after in_last until the frame ends).
- Byte boundary (end of the final bit of a byte), evaluated in this order:
  - Buffer full: buffer moves to the shift register, the buffer empties, and the next byte's MSB is driven.
  - Buffer empty but a handshake occurs on the same cycle: the byte bypasses straight to the shift register. No underrun.
  - Current byte was last: state goes to DONE.
  - Otherwise: underrun pulses, state goes to IDLE, and outputs take idle values.
- DONE: lasts one cycle. frame_done=1, fsk_phase=0, fsk_enable=1, busy=0. Next state IDLE.
- sample_en low: phase, bit index and preamble count hold. A handshake into an empty buffer still proceeds.
- Back-to-back frames: a new frame may start in IDLE the cycle after DONE. There is no implicit gap.

Optional Feature:
- Macro FSK_PARITY_EN.
- Defined: after the 8 data bits of each byte, a 9th bit equal to even parity (XOR of the 8 bits) is sent for one bit period. The byte boundary moves to the end of the parity bit.
- Undefined: 8 bits per byte, no parity logic present.

Test Plan:
- PHASE_STEP=32, sample_en=1, single byte 0xA5 with in_last=1:
  - fsk_phase cycles 0,32,...,224 each bit.
  - fsk_enable is 1,0,1,0,1,0,1,0 (8 cycles each), then 1,0,1,0,0,1,0,1.
  - frame_done pulses 1 cycle after cycle 128 of the frame; busy high for exactly 128 cycles.
- Two bytes 0x3C, 0xFF (last) with in_valid always high:
  - Second byte is accepted during the first byte's DATA.
  - Bits are contiguous, no gap; total busy = 64+128 cycles.
- Two-byte frame, second byte withheld past the first byte's final boundary:
  - underrun pulses once, state returns to IDLE, fsk_enable=1, fsk_phase=0, and frame_done is never asserted.
- Bypass case: buffer empty, in_valid rises exactly on the byte-boundary cycle:
  - Byte is sent with no underrun.
- sample_en=1 every 4th cycle, byte 0x80 last:
  - Each phase value is held 4 cycles and total busy = 512 cycles.
  - rst_n pulsed low mid-DATA: outputs go to idle values immediately and in_ready=1.
- FSK_PARITY_EN defined, byte 0x07 last:
  - Data bits 00000111 followed by parity bit 1.
  - Frame length = (8+9)*8 = 136 cycles.
